// File: rtl/fetch_unit.sv
// RV32I fetch stage: one outstanding imem request, {pc, instr} handed to decode via valid/ready.
// Latency REQ->WAIT->HOLD (3 cycles at 1-cycle memory); holds instr/pc stable while instr_ready=0.
module fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_rvalid,
  input  logic [31:0]      imem_rdata,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [31:0]      instr,
  output logic [XLEN-1:0]  pc,
  input  logic             pc_src,
  input  logic [XLEN-1:0]  imm_ext,
  output logic             fetch_fault,
  output logic [CNT_W-1:0] retired_count
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FAULT
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
  } fetch_pkt_t;

  state_t           state_q;
  state_t           state_d;
  logic [XLEN-1:0]  fetch_pc_q;
  fetch_pkt_t       pkt_q;
  logic [CNT_W-1:0] retired_q;

  logic             accept;
  logic             rsp_take;
  logic [XLEN-1:0]  next_pc;
  logic             next_misaligned;

  assign accept          = (state_q == S_HOLD) && instr_ready;
  assign rsp_take        = (state_q == S_WAIT) && imem_rvalid;
  assign next_pc         = pc_src ? (pkt_q.pc + imm_ext) : (pkt_q.pc + XLEN'(4));
  assign next_misaligned = |next_pc[1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_REQ;
      S_REQ:   state_d = S_WAIT;
      S_WAIT:  if (imem_rvalid) state_d = S_HOLD;
      S_HOLD:  if (instr_ready) state_d = next_misaligned ? S_FAULT : S_REQ;
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_IDLE;
    endcase
  end

  // Every output decodes flopped state, so instr_ready never reaches imem_req combinationally.
  always_comb begin
    imem_req      = (state_q == S_REQ);
    instr_valid   = (state_q == S_HOLD);
    fetch_fault   = (state_q == S_FAULT);
    imem_addr     = fetch_pc_q;
    instr         = pkt_q.instr;
    pc            = pkt_q.pc;
    retired_count = retired_q;
  end

  // On a misaligned target the faulting address is kept in fetch_pc_q only; pc keeps the last accepted one.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      pkt_q      <= '{pc: RESET_PC, instr: NOP};
      retired_q  <= '0;
    end else begin
      if (rsp_take) begin
        pkt_q <= '{pc: fetch_pc_q, instr: imem_rdata};
      end
      if (accept) begin
        fetch_pc_q <= next_pc;
        retired_q  <= retired_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the control unit and datapath in the RV32I core.
- Holds the PC and fetches one instruction at a time over a request/response instruction-memory port.
- Presents `{pc, instr}` to decode with a valid/ready handshake.
- When decode accepts an instruction, computes the next PC from the resolved `pc_src` and the immediate. It stops fetching and flags a fault on a misaligned target.

Parameters:
- XLEN, 32, data/address width.
- RESET_PC, 32'h0000_0000, PC loaded on reset; must be 4-byte aligned.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- imem_req  out  1  single-cycle fetch request pulse.
- imem_addr  out  XLEN  fetch address; valid while imem_req=1.
- imem_rvalid  in  1  response strobe; earliest 1 cycle after imem_req.
- imem_rdata  in  32  instruction word; valid with imem_rvalid.
- instr_valid  out  1  instr/pc hold a fetched instruction.
- instr_ready  in  1  decode/execute consumes instruction this cycle.
- instr  out  32  fetched instruction.
- pc  out  XLEN  address of instr.
- pc_src  in  1  branch taken for the instruction being accepted.
- imm_ext  in  XLEN  sign-extended branch offset for that instruction.
- fetch_fault  out  1  sticky misaligned-target flag.
- retired_count  out  CNT_W  number of accepted instructions.

Behaviour:
- Reset (rst=1 at edge):
  - State goes to IDLE; internal PC = RESET_PC.
  - Outputs: imem_req=0, instr_valid=0, instr=32'h0000_0013 (NOP), pc=RESET_PC, fetch_fault=0, retired_count=0.
  - Reset dominates every other input in the same cycle.
- FSM states: IDLE, REQ, WAIT, HOLD, FAULT.
- IDLE: unconditionally goes to REQ next cycle. Any imem_rvalid received in IDLE is dropped.
- REQ:
  - imem_req=1, imem_addr=internal PC, for exactly one cycle.
  - Next state WAIT.
  - imem_rvalid in this cycle is ignored.
- WAIT:
  - Stays in WAIT until imem_rvalid=1.
  - On rvalid: instr<=imem_rdata, pc<=internal PC, go to HOLD.
  - No timeout.
- HOLD:
  - instr_valid=1; instr and pc stay stable while instr_ready=0.
  - On instr_valid & instr_ready (accept):
    - next = pc_src ? pc + imm_ext : pc + 4, computed modulo 2^XLEN (wraps).
    - retired_count increments, wrapping at 2^CNT_W.
    - If next[1:0] != 0: go to FAULT, fetch_fault<=1, internal PC <= next (recorded).
    - Otherwise: internal PC <= next and go to REQ, so imem_req asserts the cycle after accept.
  - pc_src and imm_ext are sampled only at accept; they are don't-care at all other times.
- FAULT:
  - Terminal until rst.
  - imem_req=0, instr_valid=0, fetch_fault=1.
  - pc shows the last accepted instruction's address; the faulting target is not exposed.
  - imem_rvalid is ignored.
- Outputs outside their states:
  - instr_valid=0 in every state except HOLD.
  - imem_req=1 only in REQ.
- Throughput: with 1-cycle memory latency, one instruction per 3 cycles (REQ, WAIT, HOLD with ready=1).
- Single outstanding request only.
- Memory contract: the memory must be reset by the same rst. Stale responses after reset are not tracked.
- Outputs are registered; there is no combinational path from instr_ready to imem_req.

Test Plan:
- Reset release, RESET_PC=0, memory latency 1, instr_ready=1 → imem_req at cycle 1 addr 0x0, then 0x4, 0x8 every 3 cycles; retired_count=3 after third accept.
- Taken branch: accept at pc=0x10 with pc_src=1, imm_ext=0xFFFF_FFF8 → next imem_addr=0x08; with pc_src=0, imm_ext=0x100 → next imem_addr=0x14.
- Backpressure: instr_ready=0 for 5 cycles in HOLD → instr and pc unchanged, no imem_req, retired_count unchanged; instr_ready=1 → single accept.
- Misaligned target: accept at pc=0x20, pc_src=1, imm_ext=0x2 → fetch_fault=1 next cycle, instr_valid and imem_req stay 0 for 20 cycles; rst → fetch_fault=0, imem_req at addr RESET_PC.
- Variable latency: rvalid 7 cycles after req, plus spurious rvalid in IDLE and in REQ → only the WAIT-state response is captured, with the correct rdata.
- Reset mid-WAIT, and wrap: rst during WAIT → instr_valid=0, pc=RESET_PC next cycle. Accept at pc=0xFFFF_FFFC with pc_src=0 → imem_addr=0x0.
